alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// Upstream issue stage for the 16-bit ALU: accepts one operation per valid/ready handshake,
// decodes the 4-bit op code into a one-hot unit enable (ARITH/LOGIC/CMP/SHIFT) plus a 2-bit unit
// function, and holds operands stable while the selected unit works. After the unit latency it
// captures that unit's result and flag and presents them downstream on a second valid/ready handshake.
// PARAMETERS
// IN_WIDTH      16  operand width (op_in1/op_in2, unit_in1/unit_in2)
// OUT_WIDTH     16  unit result width and res_out width
// UNIT_LATENCY  1   clk cycles from the enable-high cycle to unit output valid; legal range 1..7
// PORTS
// clk        in   1          rising-edge clock
// rst        in   1          synchronous reset, active-high
// op_valid   in   1          upstream operation valid
// op_ready   out  1          sequencer can accept an op
// op_in1     in   IN_WIDTH   operand A
// op_in2     in   IN_WIDTH   operand B
// op_fun     in   4          [3:2] unit: 00 arith, 01 logic, 10 cmp, 11 shift; [1:0] unit function
// unit_in1   out  IN_WIDTH   registered operand A to all units
// unit_in2   out  IN_WIDTH   registered operand B to all units
// unit_fun   out  2          registered op_fun[1:0] to all units
// arith_en / logic_en / cmp_en / shift_en   out  1 each   unit enables, at most one high
// arith_out / logic_out / cmp_out / shift_out  in  OUT_WIDTH each   unit results
// arith_flag / logic_flag / cmp_flag / shift_flag  in  1 each   unit flags
// res_out    out  OUT_WIDTH  captured result of the selected unit
// res_flag   out  1          captured flag of the selected unit
// res_unit   out  2          op_fun[3:2] of the op that produced res_out
// res_valid  out  1          result valid
// res_ready  in   1          downstream accepts the result
// BEHAVIOUR
// - All outputs are registered except op_ready, which is decoded from state.
// - Reset (rst=1 at a clk edge): state=IDLE, all en=0, res_valid=0, and unit_in*, unit_fun,
//   res_out, res_flag, res_unit all 0. Reset wins over every other event.
// - FSM states: IDLE, ISSUE, WAIT, HOLD.
// - IDLE: op_ready=1, no other state asserts op_ready.
//   On op_valid=1, latch op_in1/op_in2/op_fun into unit_in1/unit_in2/unit_fun and an internal unit
//   select, then go to ISSUE.
// - ISSUE: exactly one cycle. Only the enable matching unit select is 1. Next state is WAIT with
//   counter = UNIT_LATENCY-1.
// - WAIT: all enables 0, operands unchanged. Lasts UNIT_LATENCY cycles.
//   At the edge ending the last WAIT cycle, capture the selected unit's out/flag into
//   res_out/res_flag, set res_unit, set res_valid=1, and go to HOLD.
// - HOLD: res_* stable while res_valid=1. On res_ready=1, res_valid clears at that edge and the
//   state returns to IDLE. res_out/res_flag keep their last value after the handshake.
// - Latency: accept edge to res_valid high is UNIT_LATENCY+2 edges. Minimum op spacing is
//   UNIT_LATENCY+3 cycles.
// - unit_in*/unit_fun change only on an accept edge or on reset. Enables are never high outside
//   ISSUE.
// - op_valid in non-IDLE states is ignored; the op is not consumed. res_ready outside HOLD is ignored.
// - Reset mid-ISSUE/WAIT/HOLD: the in-flight op is dropped, and no res_valid pulse follows.
// TESTING
// - Equal compare: rst 2 cycles, then op_fun=4'b1001, in1=15, in2=15, res_ready=1.
//   Expect cmp_en high for exactly 1 cycle, res_valid 3 edges after accept, res_out=16'd1, res_unit=2'b10.
// - Greater-than: op_fun=4'b1010, in1=17, in2=15.
//   Expect unit_fun=2'b10 and res_out=16'd2 captured from cmp_out.
// - Backpressure: hold res_ready=0 for 5 cycles in HOLD.
//   Expect res_valid, res_out and res_flag stable, op_ready=0, and a second op_valid not accepted.
//   Then res_ready=1 gives IDLE next cycle and op_ready=1.
// - Decode sweep: all 16 op_fun codes.
//   Expect exactly one enable high in ISSUE matching op_fun[3:2], and unit_fun=op_fun[1:0].
//   res_out must equal the stubbed out of that unit only (stubs drive distinct constants such as
//   16'hA001, 16'hB002).
// - Reset mid-op: assert rst during WAIT.
//   Expect all enables 0, res_valid 0 and res_out 0 after that edge, no later res_valid pulse,
//   and op_ready=1 once rst drops.
// - Latency param: UNIT_LATENCY=3 with a delayed stub unit.
//   Expect res_valid 5 edges after accept, and the captured value is the stub's value at that cycle.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Operation issue and result return handshakes between the ALU sequencer and its neighbours.
// The master side issues operations and consumes results; the slave side is the sequencer.
interface alu_op_sequencer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic                 op_valid;
  logic                 op_ready;
  logic [IN_WIDTH-1:0]  op_in1;
  logic [IN_WIDTH-1:0]  op_in2;
  logic [3:0]           op_fun;
  logic [OUT_WIDTH-1:0] res_out;
  logic                 res_flag;
  logic [1:0]           res_unit;
  logic                 res_valid;
  logic                 res_ready;

  modport master (
    output op_valid, op_in1, op_in2, op_fun, res_ready,
    input  op_ready, res_out, res_flag, res_unit, res_valid
  );

  modport slave (
    input  op_valid, op_in1, op_in2, op_fun, res_ready,
    output op_ready, res_out, res_flag, res_unit, res_valid
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 16-bit ALU: accepts one op, pulses the selected unit enable for one cycle,
// waits out the unit latency, captures that unit's result/flag and hands it downstream.
module alu_op_sequencer #(
  parameter int IN_WIDTH     = 16,
  parameter int OUT_WIDTH    = 16,
  parameter int UNIT_LATENCY = 1    // legal range 1..7
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_op_sequencer_if.slave    bus,
  output logic [IN_WIDTH-1:0]  unit_in1,
  output logic [IN_WIDTH-1:0]  unit_in2,
  output logic [1:0]           unit_fun,
  output logic                 arith_en,
  output logic                 logic_en,
  output logic                 cmp_en,
  output logic                 shift_en,
  input  logic [OUT_WIDTH-1:0] arith_out,
  input  logic [OUT_WIDTH-1:0] logic_out,
  input  logic [OUT_WIDTH-1:0] cmp_out,
  input  logic [OUT_WIDTH-1:0] shift_out,
  input  logic                 arith_flag,
  input  logic                 logic_flag,
  input  logic                 cmp_flag,
  input  logic                 shift_flag
);

  // WAIT counter reload: the counter counts down to zero across UNIT_LATENCY WAIT cycles.
  localparam logic [2:0] WAIT_LOAD = 3'(UNIT_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [2:0]           cnt_r;
  logic [2:0]           cnt_s;
  logic [1:0]           sel_r;
  logic [3:0]           en_r;
  logic                 accept_s;
  logic                 capture_s;
  logic                 release_s;
  logic [OUT_WIDTH-1:0] cap_out_s;
  logic                 cap_flag_s;

  // Unit select to one-hot enable: bit0 arith, bit1 logic, bit2 cmp, bit3 shift.
  function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
    logic [3:0] oh;
    case (unit)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // Only IDLE accepts work; op_ready is a pure state decode.
  assign bus.op_ready = (state_r == ST_IDLE);

  assign arith_en = en_r[0];
  assign logic_en = en_r[1];
  assign cmp_en   = en_r[2];
  assign shift_en = en_r[3];

  // Next-state logic and the accept/capture/release strobes that drive the datapath registers.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.op_valid) begin
          accept_s = 1'b1;
          state_s  = ST_ISSUE;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
        cnt_s   = WAIT_LOAD;
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          capture_s = 1'b1;
          state_s   = ST_HOLD;
        end else begin
          cnt_s     = cnt_r - 3'd1;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          release_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s   = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // Result mux: pick the out/flag of the unit chosen when the op was accepted.
  always_comb begin
    cap_out_s  = {OUT_WIDTH{1'b0}};
    cap_flag_s = 1'b0;
    case (sel_r)
      2'd0: begin
        cap_out_s  = arith_out;
        cap_flag_s = arith_flag;
      end
      2'd1: begin
        cap_out_s  = logic_out;
        cap_flag_s = logic_flag;
      end
      2'd2: begin
        cap_out_s  = cmp_out;
        cap_flag_s = cmp_flag;
      end
      2'd3: begin
        cap_out_s  = shift_out;
        cap_flag_s = shift_flag;
      end
      default: begin
        cap_out_s  = {OUT_WIDTH{1'b0}};
        cap_flag_s = 1'b0;
      end
    endcase
  end

  // State, WAIT counter and enable register; the enable is high only for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      en_r    <= 4'b0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      en_r    <= accept_s ? unit_onehot(bus.op_fun[3:2]) : 4'b0000;
    end
  end

  // Operand/function/select registers, loaded only on an accept edge so units see stable inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      unit_in1 <= {IN_WIDTH{1'b0}};
      unit_in2 <= {IN_WIDTH{1'b0}};
      unit_fun <= 2'd0;
      sel_r    <= 2'd0;
    end else if (accept_s) begin
      unit_in1 <= bus.op_in1;
      unit_in2 <= bus.op_in2;
      unit_fun <= bus.op_fun[1:0];
      sel_r    <= bus.op_fun[3:2];
    end
  end

  // Result registers: captured at the end of WAIT, held through HOLD and retained after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_out   <= {OUT_WIDTH{1'b0}};
      bus.res_flag  <= 1'b0;
      bus.res_unit  <= 2'd0;
      bus.res_valid <= 1'b0;
    end else if (capture_s) begin
      bus.res_out   <= cap_out_s;
      bus.res_flag  <= cap_flag_s;
      bus.res_unit  <= sel_r;
      bus.res_valid <= 1'b1;
    end else if (release_s) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: two sequencers (unit latency 1 and 3) with stub units, directed and
// random ops, checked against an op-level reference of the expected result and its timing.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cyc = 16'd0;
  logic        which = 1'b0;   // 0: latency-1 instance, 1: latency-3 instance
  logic        op_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [15:0] op_in1 = 16'd0;
  logic [15:0] op_in2 = 16'd0;
  logic [3:0]  op_fun = 4'd0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  // Free-running cycle count; the latency-3 stubs derive their outputs from it.
  always @(posedge clk) cyc <= cyc + 16'd1;

  alu_op_sequencer_if #(.IN_WIDTH(16), .OUT_WIDTH(16)) if1 ();
  alu_op_sequencer_if #(.IN_WIDTH(16), .OUT_WIDTH(16)) if3 ();

  assign if1.op_valid  = op_valid & ~which;
  assign if3.op_valid  = op_valid & which;
  assign if1.res_ready = res_ready & ~which;
  assign if3.res_ready = res_ready & which;
  assign if1.op_in1 = op_in1;
  assign if1.op_in2 = op_in2;
  assign if1.op_fun = op_fun;
  assign if3.op_in1 = op_in1;
  assign if3.op_in2 = op_in2;
  assign if3.op_fun = op_fun;

  logic [15:0] u1_in1, u1_in2, u3_in1, u3_in2;
  logic [1:0]  u1_fun, u3_fun;
  logic [3:0]  en1, en3;
  logic [15:0] o1 [4];
  logic [15:0] o3 [4];
  logic        f1 [4];
  logic        f3 [4];

  // Behaviour of each unit for an op (unit select, function, operands): {flag, out}.
  function automatic logic [16:0] unit_behav(input logic [1:0] unit, input logic [1:0] fun,
                                             input logic [15:0] a, input logic [15:0] b);
    logic c;
    c = 1'b0;
    case (unit)
      2'd0: return {a[0], a + b + 16'hA001};
      2'd1: return {b[0], (a & b) ^ 16'hB002};
      2'd2: begin
        case (fun)
          2'd0:    c = (a < b);
          2'd1:    c = (a == b);
          2'd2:    c = (a > b);
          default: c = (a != b);
        endcase
        return {c, c ? {14'd0, fun} : 16'hC003};
      end
      default: return {a[15], (a << b[3:0]) ^ 16'hD004};
    endcase
  endfunction

  // Delayed stub units: outputs move every cycle, so only a correctly timed capture matches.
  function automatic logic [16:0] d3_val(input logic [1:0] unit, input logic [15:0] c);
    logic [15:0] base;
    case (unit)
      2'd0:    base = 16'hA001;
      2'd1:    base = 16'hB002;
      2'd2:    base = 16'hC003;
      default: base = 16'hD004;
    endcase
    return {c[unit[0]] ^ unit[1], c ^ base};
  endfunction

  // Stub units for both instances.
  always_comb begin
    {f1[0], o1[0]} = unit_behav(2'd0, u1_fun, u1_in1, u1_in2);
    {f1[1], o1[1]} = unit_behav(2'd1, u1_fun, u1_in1, u1_in2);
    {f1[2], o1[2]} = unit_behav(2'd2, u1_fun, u1_in1, u1_in2);
    {f1[3], o1[3]} = unit_behav(2'd3, u1_fun, u1_in1, u1_in2);
    {f3[0], o3[0]} = d3_val(2'd0, cyc);
    {f3[1], o3[1]} = d3_val(2'd1, cyc);
    {f3[2], o3[2]} = d3_val(2'd2, cyc);
    {f3[3], o3[3]} = d3_val(2'd3, cyc);
  end

  alu_op_sequencer #(.IN_WIDTH(16), .OUT_WIDTH(16), .UNIT_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1),
    .unit_in1(u1_in1), .unit_in2(u1_in2), .unit_fun(u1_fun),
    .arith_en(en1[0]), .logic_en(en1[1]), .cmp_en(en1[2]), .shift_en(en1[3]),
    .arith_out(o1[0]), .logic_out(o1[1]), .cmp_out(o1[2]), .shift_out(o1[3]),
    .arith_flag(f1[0]), .logic_flag(f1[1]), .cmp_flag(f1[2]), .shift_flag(f1[3])
  );

  alu_op_sequencer #(.IN_WIDTH(16), .OUT_WIDTH(16), .UNIT_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3),
    .unit_in1(u3_in1), .unit_in2(u3_in2), .unit_fun(u3_fun),
    .arith_en(en3[0]), .logic_en(en3[1]), .cmp_en(en3[2]), .shift_en(en3[3]),
    .arith_out(o3[0]), .logic_out(o3[1]), .cmp_out(o3[2]), .shift_out(o3[3]),
    .arith_flag(f3[0]), .logic_flag(f3[1]), .cmp_flag(f3[2]), .shift_flag(f3[3])
  );

  logic        v_op_ready, v_res_valid, v_res_flag;
  logic [15:0] v_in1, v_in2, v_res_out;
  logic [1:0]  v_fun, v_res_unit;
  logic [3:0]  v_en;

  // View of whichever instance is under test.
  always_comb begin
    if (which) begin
      v_op_ready = if3.op_ready; v_res_valid = if3.res_valid; v_res_flag = if3.res_flag;
      v_res_out = if3.res_out; v_res_unit = if3.res_unit;
      v_in1 = u3_in1; v_in2 = u3_in2; v_fun = u3_fun; v_en = en3;
    end else begin
      v_op_ready = if1.op_ready; v_res_valid = if1.res_valid; v_res_flag = if1.res_flag;
      v_res_out = if1.res_out; v_res_unit = if1.res_unit;
      v_in1 = u1_in1; v_in2 = u1_in2; v_fun = u1_fun; v_en = en1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "/op_ready"}, 32'(v_op_ready), 32'd1);
    chk({tag, "/en"}, 32'(v_en), 32'd0);
    chk({tag, "/res_valid"}, 32'(v_res_valid), 32'd0);
    chk({tag, "/res_out"}, 32'(v_res_out), 32'd0);
    chk({tag, "/res_flag"}, 32'(v_res_flag), 32'd0);
    chk({tag, "/res_unit"}, 32'(v_res_unit), 32'd0);
    chk({tag, "/unit_in1"}, 32'(v_in1), 32'd0);
    chk({tag, "/unit_in2"}, 32'(v_in2), 32'd0);
    chk({tag, "/unit_fun"}, 32'(v_fun), 32'd0);
  endtask

  // One complete op: issue, expected enable/operands, latency, result, backpressure, release.
  // Called at a negedge with the instance idle; returns at a negedge with it idle again.
  task automatic run_op(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                        input int stall, input string tag);
    int          lat;
    int          edges;
    logic [15:0] acc;
    logic [16:0] exp;
    logic [3:0]  one;
    lat = which ? 3 : 1;
    one = 4'b0001 << fun[3:2];
    chk({tag, "/op_ready_idle"}, 32'(v_op_ready), 32'd1);
    op_valid = 1'b1; op_in1 = a; op_in2 = b; op_fun = fun; acc = cyc;
    tick();
    // Keep offering a different op: it must be ignored until the sequencer is idle again.
    op_in1 = ~a; op_in2 = ~b; op_fun = ~fun;
    chk({tag, "/issue_en"}, 32'(v_en), 32'(one));
    chk({tag, "/unit_in1"}, 32'(v_in1), 32'(a));
    chk({tag, "/unit_in2"}, 32'(v_in2), 32'(b));
    chk({tag, "/unit_fun"}, 32'(v_fun), 32'(fun[1:0]));
    chk({tag, "/busy_ready"}, 32'(v_op_ready), 32'd0);
    chk({tag, "/issue_valid"}, 32'(v_res_valid), 32'd0);
    edges = 0;
    while (v_res_valid !== 1'b1 && edges < 16) begin
      tick();
      edges++;
      if (v_res_valid !== 1'b1) begin
        chk({tag, "/wait_en"}, 32'(v_en), 32'd0);
        chk({tag, "/wait_in1"}, 32'(v_in1), 32'(a));
      end
    end
    chk({tag, "/latency_edges"}, 32'(edges + 1), 32'(lat + 2));
    if (which) exp = d3_val(fun[3:2], 16'(acc + 16'(lat + 1)));
    else       exp = unit_behav(fun[3:2], fun[1:0], a, b);
    chk({tag, "/res_out"}, 32'(v_res_out), 32'(exp[15:0]));
    chk({tag, "/res_flag"}, 32'(v_res_flag), 32'(exp[16]));
    chk({tag, "/res_unit"}, 32'(v_res_unit), 32'(fun[3:2]));
    chk({tag, "/hold_ready"}, 32'(v_op_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({tag, "/bp_valid"}, 32'(v_res_valid), 32'd1);
      chk({tag, "/bp_out"}, 32'(v_res_out), 32'(exp[15:0]));
      chk({tag, "/bp_flag"}, 32'(v_res_flag), 32'(exp[16]));
      chk({tag, "/bp_ready"}, 32'(v_op_ready), 32'd0);
      chk({tag, "/bp_in1"}, 32'(v_in1), 32'(a));
    end
    res_ready = 1'b1; op_valid = 1'b0;
    tick();
    res_ready = 1'b0;
    chk({tag, "/done_valid"}, 32'(v_res_valid), 32'd0);
    chk({tag, "/done_ready"}, 32'(v_op_ready), 32'd1);
    chk({tag, "/done_out_kept"}, 32'(v_res_out), 32'(exp[15:0]));
  endtask

  initial begin
    // Reset state of both instances.
    rst = 1'b1;
    tick();
    tick();
    which = 1'b0;
    check_reset_state("reset1");
    which = 1'b1;
    check_reset_state("reset3");
    rst = 1'b0;
    which = 1'b0;
    tick();

    // Directed compares and backpressure on the latency-1 instance.
    run_op(4'b1001, 16'd15, 16'd15, 0, "cmp_eq");
    run_op(4'b1010, 16'd17, 16'd15, 0, "cmp_gt");
    run_op(4'b0001, 16'h1357, 16'h2468, 5, "backpressure");

    // Decode sweep over all 16 op codes.
    for (int i = 0; i < 16; i++)
      run_op(4'(i), 16'h1230 + 16'(i), 16'h0F05, i % 2, "sweep");

    // Random ops.
    for (int i = 0; i < 30; i++)
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)), "rand1");

    // Reset while the op is in WAIT: op dropped, no later result.
    op_valid = 1'b1; op_fun = 4'b0110; op_in1 = 16'h00F0; op_in2 = 16'h0FF0;
    tick();
    op_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("rst_mid_wait");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_result", 32'(v_res_valid), 32'd0);
    end
    chk("rst_ready_after", 32'(v_op_ready), 32'd1);

    // Latency-3 instance with time-varying stubs.
    which = 1'b1;
    run_op(4'b1001, 16'd15, 16'd15, 0, "lat3_cmp");
    run_op(4'b0010, 16'h4444, 16'h5555, 2, "lat3_logic");
    for (int i = 0; i < 10; i++)
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)), "rand3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
